tl_buffered_coupler: RTL and testbench



---
 rtl/tl_coupler_pkg.sv | 63 ++++++
 rtl/tl_coupler_queue.sv | 64 ++++++
 rtl/tl_buffered_coupler.sv | 125 ++++++++++++
 tb/tb_tl_buffered_coupler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_coupler_pkg.sv
// Shared TileLink coupler definitions: channel widths, opcodes, field offsets
// and burst-length helpers.
package tl_coupler_pkg;

    // Opcodes that carry a data payload
    localparam logic [2:0] OP_PUT_FULL       = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL    = 3'd1;
    localparam logic [2:0] OP_ARITHMETIC     = 3'd2;
    localparam logic [2:0] OP_LOGICAL        = 3'd3;
    localparam logic [2:0] OP_PROBE_ACK_DATA = 3'd5;
    localparam logic [2:0] OP_RELEASE_DATA   = 3'd7;

    // {opcode[3], param[3], size, source, address, mask, data, corrupt}
    function automatic int a_width(input int addr_w, input int data_w,
                                   input int size_w, input int source_w);
        return 7 + size_w + source_w + addr_w + data_w / 8 + data_w;
    endfunction

    // Same as A but with a 2-bit param
    function automatic int b_width(input int addr_w, input int data_w,
                                   input int size_w, input int source_w);
        return a_width(addr_w, data_w, size_w, source_w) - 1;
    endfunction

    // {opcode[3], param[3], size, source, address, data, corrupt}
    function automatic int c_width(input int addr_w, input int data_w,
                                   input int size_w, input int source_w);
        return 7 + size_w + source_w + addr_w + data_w;
    endfunction

    // {opcode[3], param[2], size, source, sink, denied, data, corrupt}
    function automatic int d_width(input int data_w, input int size_w,
                                   input int source_w, input int sink_w);
        return 7 + size_w + source_w + sink_w + data_w;
    endfunction

    // Opcode always sits in the top three bits; size follows a 3-bit param
    function automatic int opcode_msb(input int w);
        return w - 1;
    endfunction

    function automatic int size_msb(input int w);
        return w - 7;
    endfunction

    function automatic logic has_data_a(input logic [2:0] op);
        return (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL) ||
               (op == OP_ARITHMETIC) || (op == OP_LOGICAL);
    endfunction

    function automatic logic has_data_c(input logic [2:0] op);
        return (op == OP_PROBE_ACK_DATA) || (op == OP_RELEASE_DATA);
    endfunction

    // Beats in a message: multi-beat only when it carries data wider than a beat
    function automatic logic [31:0] beats(input int unsigned size, input logic has_data,
                                          input int unsigned lg_bytes);
        if (has_data && size > lg_bytes)
            return 32'd1 << (size - lg_bytes);
        return 32'd1;
    endfunction

endpackage

// File: rtl/tl_coupler_queue.sv
// Single-channel ready/valid FIFO; DEPTH=0 degenerates to a wire.
module tl_coupler_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enq_valid,
    input  logic [W-1:0] enq_bits,
    output logic         enq_ready,
    output logic         deq_valid,
    output logic [W-1:0] deq_bits,
    input  logic         deq_ready,
    output logic         empty
);

    if (DEPTH == 0) begin : g_wire
        assign deq_valid = enq_valid;
        assign deq_bits  = enq_bits;
        assign enq_ready = deq_ready;
        assign empty     = 1'b1;
        wire unused_clk_rst = clock ^ reset;
    end else begin : g_fifo
        localparam int CW = $clog2(DEPTH + 1);
        localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

        logic [W-1:0]  mem [DEPTH];
        logic [PW-1:0] head, tail;
        logic [CW-1:0] count;
        logic          enq, deq;

        function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
            return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
        endfunction

        // Ready never looks at deq_ready: a full queue refuses even while draining
        assign enq_ready = (count < CW'(DEPTH));
        assign deq_valid = (count != '0);
        assign deq_bits  = mem[head];
        assign empty     = (count == '0);
        assign enq       = enq_valid & enq_ready;
        assign deq       = deq_valid & deq_ready;

        // Pointer and occupancy bookkeeping
        always_ff @(posedge clock) begin
            if (reset) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) tail <= next_ptr(tail);
                if (deq) head <= next_ptr(head);
                if (enq && !deq)      count <= count + CW'(1);
                else if (deq && !enq) count <= count - CW'(1);
            end
        end

        // Storage write; contents need no reset since count gates visibility
        always_ff @(posedge clock) begin
            if (enq) mem[tail] <= enq_bits;
        end
    end

endmodule

// File: rtl/tl_buffered_coupler.sv
// Five-channel TileLink coupler with per-channel FIFOs and a quiesce/drain
// handshake that only blocks A/C at message boundaries.
module tl_buffered_coupler import tl_coupler_pkg::*; #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int SIZE_W   = 4,
    parameter int SOURCE_W = 3,
    parameter int SINK_W   = 2,
    parameter int A_DEPTH  = 2,
    parameter int B_DEPTH  = 2,
    parameter int C_DEPTH  = 2,
    parameter int D_DEPTH  = 2,
    parameter int E_DEPTH  = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic in_a_valid,
    input  logic [a_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W)-1:0] in_a_bits,
    output logic in_a_ready,
    output logic out_a_valid,
    output logic [a_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W)-1:0] out_a_bits,
    input  logic out_a_ready,
    input  logic out_b_valid,
    input  logic [b_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W)-1:0] out_b_bits,
    output logic out_b_ready,
    output logic in_b_valid,
    output logic [b_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W)-1:0] in_b_bits,
    input  logic in_b_ready,
    input  logic in_c_valid,
    input  logic [c_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W)-1:0] in_c_bits,
    output logic in_c_ready,
    output logic out_c_valid,
    output logic [c_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W)-1:0] out_c_bits,
    input  logic out_c_ready,
    input  logic out_d_valid,
    input  logic [d_width(DATA_W, SIZE_W, SOURCE_W, SINK_W)-1:0] out_d_bits,
    output logic out_d_ready,
    output logic in_d_valid,
    output logic [d_width(DATA_W, SIZE_W, SOURCE_W, SINK_W)-1:0] in_d_bits,
    input  logic in_d_ready,
    input  logic in_e_valid,
    input  logic [SINK_W-1:0] in_e_bits,
    output logic in_e_ready,
    output logic out_e_valid,
    output logic [SINK_W-1:0] out_e_bits,
    input  logic out_e_ready,
    input  logic quiesce_req,
    output logic idle
);

    localparam int A_W      = a_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W);
    localparam int B_W      = b_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W);
    localparam int C_W      = c_width(ADDR_W, DATA_W, SIZE_W, SOURCE_W);
    localparam int D_W      = d_width(DATA_W, SIZE_W, SOURCE_W, SINK_W);
    localparam int LG_BYTES = $clog2(DATA_W / 8);
    // Wide enough for the largest possible beat count minus one
    localparam int REM_W    = 1 << SIZE_W;

    logic [REM_W-1:0] a_rem, c_rem;
    logic             a_open, c_open, block_a, block_c;
    logic             a_enq_ready, c_enq_ready, a_fire, c_fire;
    logic             a_empty, b_empty, c_empty, d_empty, e_empty;
    logic [31:0]      a_beats, c_beats;

    assign a_open  = (a_rem != '0);
    assign c_open  = (c_rem != '0);
    assign block_a = quiesce_req & ~a_open;
    assign block_c = quiesce_req & ~c_open;

    assign in_a_ready = a_enq_ready & ~block_a;
    assign in_c_ready = c_enq_ready & ~block_c;
    assign a_fire     = in_a_valid & in_a_ready;
    assign c_fire     = in_c_valid & in_c_ready;

    assign a_beats = beats(32'(in_a_bits[size_msb(A_W) -: SIZE_W]),
                           has_data_a(in_a_bits[opcode_msb(A_W) -: 3]), LG_BYTES);
    assign c_beats = beats(32'(in_c_bits[size_msb(C_W) -: SIZE_W]),
                           has_data_c(in_c_bits[opcode_msb(C_W) -: 3]), LG_BYTES);

    assign idle = quiesce_req & ~a_open & ~c_open &
                  a_empty & b_empty & c_empty & d_empty & e_empty;

    // Track beats still owed by the A/C message currently being accepted
    always_ff @(posedge clock) begin
        if (reset) begin
            a_rem <= '0;
            c_rem <= '0;
        end else begin
            if (a_fire) a_rem <= (a_rem == '0) ? REM_W'(a_beats - 32'd1) : a_rem - REM_W'(1);
            if (c_fire) c_rem <= (c_rem == '0) ? REM_W'(c_beats - 32'd1) : c_rem - REM_W'(1);
        end
    end

    // Gating enq_valid also zeroes out_*_valid when a queue is a bare wire
    tl_coupler_queue #(.W(A_W), .DEPTH(A_DEPTH)) u_qa (
        .clock, .reset,
        .enq_valid(in_a_valid & ~block_a), .enq_bits(in_a_bits), .enq_ready(a_enq_ready),
        .deq_valid(out_a_valid), .deq_bits(out_a_bits), .deq_ready(out_a_ready),
        .empty(a_empty));

    tl_coupler_queue #(.W(B_W), .DEPTH(B_DEPTH)) u_qb (
        .clock, .reset,
        .enq_valid(out_b_valid), .enq_bits(out_b_bits), .enq_ready(out_b_ready),
        .deq_valid(in_b_valid), .deq_bits(in_b_bits), .deq_ready(in_b_ready),
        .empty(b_empty));

    tl_coupler_queue #(.W(C_W), .DEPTH(C_DEPTH)) u_qc (
        .clock, .reset,
        .enq_valid(in_c_valid & ~block_c), .enq_bits(in_c_bits), .enq_ready(c_enq_ready),
        .deq_valid(out_c_valid), .deq_bits(out_c_bits), .deq_ready(out_c_ready),
        .empty(c_empty));

    tl_coupler_queue #(.W(D_W), .DEPTH(D_DEPTH)) u_qd (
        .clock, .reset,
        .enq_valid(out_d_valid), .enq_bits(out_d_bits), .enq_ready(out_d_ready),
        .deq_valid(in_d_valid), .deq_bits(in_d_bits), .deq_ready(in_d_ready),
        .empty(d_empty));

    tl_coupler_queue #(.W(SINK_W), .DEPTH(E_DEPTH)) u_qe (
        .clock, .reset,
        .enq_valid(in_e_valid), .enq_bits(in_e_bits), .enq_ready(in_e_ready),
        .deq_valid(out_e_valid), .deq_bits(out_e_bits), .deq_ready(out_e_ready),
        .empty(e_empty));

endmodule

// File: tb/tb_tl_buffered_coupler.sv
// Directed + randomized bench for tl_buffered_coupler: a buffered instance
// (A=2, C=3, others 2) and an all-wire instance (every depth 0).
module tb_tl_buffered_coupler;

    localparam int AW = 7 + 4 + 3 + 32 + 8 + 64;
    localparam int BW = AW - 1;
    localparam int CW = 7 + 4 + 3 + 32 + 64;
    localparam int DW = 7 + 4 + 3 + 2 + 64;
    localparam int EW = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Buffered instance
    logic          in_a_valid, in_a_ready, out_a_valid, out_a_ready;
    logic [AW-1:0] in_a_bits, out_a_bits;
    logic          out_b_valid, out_b_ready, in_b_valid, in_b_ready;
    logic [BW-1:0] out_b_bits, in_b_bits;
    logic          in_c_valid, in_c_ready, out_c_valid, out_c_ready;
    logic [CW-1:0] in_c_bits, out_c_bits;
    logic          out_d_valid, out_d_ready, in_d_valid, in_d_ready;
    logic [DW-1:0] out_d_bits, in_d_bits;
    logic          in_e_valid, in_e_ready, out_e_valid, out_e_ready;
    logic [EW-1:0] in_e_bits, out_e_bits;
    logic          quiesce_req, idle;

    // Wire-only instance
    logic          z_in_a_valid, z_in_a_ready, z_out_a_valid, z_out_a_ready;
    logic [AW-1:0] z_in_a_bits, z_out_a_bits;
    logic          z_out_b_valid, z_out_b_ready, z_in_b_valid, z_in_b_ready;
    logic [BW-1:0] z_out_b_bits, z_in_b_bits;
    logic          z_in_c_valid, z_in_c_ready, z_out_c_valid, z_out_c_ready;
    logic [CW-1:0] z_in_c_bits, z_out_c_bits;
    logic          z_out_d_valid, z_out_d_ready, z_in_d_valid, z_in_d_ready;
    logic [DW-1:0] z_out_d_bits, z_in_d_bits;
    logic          z_in_e_valid, z_in_e_ready, z_out_e_valid, z_out_e_ready;
    logic [EW-1:0] z_in_e_bits, z_out_e_bits;
    logic          z_quiesce, z_idle;

    tl_buffered_coupler #(.A_DEPTH(2), .B_DEPTH(2), .C_DEPTH(3), .D_DEPTH(2), .E_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_bits(in_a_bits), .in_a_ready(in_a_ready),
        .out_a_valid(out_a_valid), .out_a_bits(out_a_bits), .out_a_ready(out_a_ready),
        .out_b_valid(out_b_valid), .out_b_bits(out_b_bits), .out_b_ready(out_b_ready),
        .in_b_valid(in_b_valid), .in_b_bits(in_b_bits), .in_b_ready(in_b_ready),
        .in_c_valid(in_c_valid), .in_c_bits(in_c_bits), .in_c_ready(in_c_ready),
        .out_c_valid(out_c_valid), .out_c_bits(out_c_bits), .out_c_ready(out_c_ready),
        .out_d_valid(out_d_valid), .out_d_bits(out_d_bits), .out_d_ready(out_d_ready),
        .in_d_valid(in_d_valid), .in_d_bits(in_d_bits), .in_d_ready(in_d_ready),
        .in_e_valid(in_e_valid), .in_e_bits(in_e_bits), .in_e_ready(in_e_ready),
        .out_e_valid(out_e_valid), .out_e_bits(out_e_bits), .out_e_ready(out_e_ready),
        .quiesce_req(quiesce_req), .idle(idle));

    tl_buffered_coupler #(.A_DEPTH(0), .B_DEPTH(0), .C_DEPTH(0), .D_DEPTH(0), .E_DEPTH(0)) dut0 (
        .clock(clock), .reset(reset),
        .in_a_valid(z_in_a_valid), .in_a_bits(z_in_a_bits), .in_a_ready(z_in_a_ready),
        .out_a_valid(z_out_a_valid), .out_a_bits(z_out_a_bits), .out_a_ready(z_out_a_ready),
        .out_b_valid(z_out_b_valid), .out_b_bits(z_out_b_bits), .out_b_ready(z_out_b_ready),
        .in_b_valid(z_in_b_valid), .in_b_bits(z_in_b_bits), .in_b_ready(z_in_b_ready),
        .in_c_valid(z_in_c_valid), .in_c_bits(z_in_c_bits), .in_c_ready(z_in_c_ready),
        .out_c_valid(z_out_c_valid), .out_c_bits(z_out_c_bits), .out_c_ready(z_out_c_ready),
        .out_d_valid(z_out_d_valid), .out_d_bits(z_out_d_bits), .out_d_ready(z_out_d_ready),
        .in_d_valid(z_in_d_valid), .in_d_bits(z_in_d_bits), .in_d_ready(z_in_d_ready),
        .in_e_valid(z_in_e_valid), .in_e_bits(z_in_e_bits), .in_e_ready(z_in_e_ready),
        .out_e_valid(z_out_e_valid), .out_e_bits(z_out_e_bits), .out_e_ready(z_out_e_ready),
        .quiesce_req(z_quiesce), .idle(z_idle));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [AW-1:0] mk_a(input logic [2:0] op, input logic [3:0] size,
                                           input logic [31:0] addr, input logic [63:0] data);
        return {op, 3'd0, size, 3'd2, addr, 8'hff, data, 1'b0};
    endfunction

    function automatic logic [CW-1:0] mk_c(input logic [2:0] op, input logic [3:0] size,
                                           input logic [63:0] data);
        return {op, 3'd0, size, 3'd1, 32'h100, data, 1'b0};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0]  ga [3];
        logic [127:0]   r;
        logic [BW-1:0]  bb;
        logic [DW-1:0]  d1, d2, d3;
        int na, nb, sent, rcvd;
        logic fire_in, got_idle;

        reset = 1; quiesce_req = 0; z_quiesce = 0;
        in_a_valid = 0; in_a_bits = '0; out_a_ready = 0;
        out_b_valid = 0; out_b_bits = '0; in_b_ready = 0;
        in_c_valid = 0; in_c_bits = '0; out_c_ready = 0;
        out_d_valid = 0; out_d_bits = '0; in_d_ready = 0;
        in_e_valid = 0; in_e_bits = '0; out_e_ready = 0;
        z_in_a_valid = 0; z_in_a_bits = '0; z_out_a_ready = 0;
        z_out_b_valid = 0; z_out_b_bits = '0; z_in_b_ready = 0;
        z_in_c_valid = 0; z_in_c_bits = '0; z_out_c_ready = 0;
        z_out_d_valid = 0; z_out_d_bits = '0; z_in_d_ready = 0;
        z_in_e_valid = 0; z_in_e_bits = '0; z_out_e_ready = 0;

        // Reset state
        cyc(); cyc();
        #2;
        chk("rst_out_a_valid", out_a_valid, 0);
        chk("rst_in_b_valid", in_b_valid, 0);
        chk("rst_out_c_valid", out_c_valid, 0);
        chk("rst_in_d_valid", in_d_valid, 0);
        chk("rst_out_e_valid", out_e_valid, 0);
        chk("rst_in_a_ready", in_a_ready, 1);
        chk("rst_in_c_ready", in_c_ready, 1);
        chk("rst_out_d_ready", out_d_ready, 1);
        chk("rst_idle_noq", idle, 0);
        quiesce_req = 1;
        #1;
        chk("rst_idle_q", idle, 1);
        cyc();
        reset = 0; quiesce_req = 0;
        cyc();

        // A queue fills at 2 with the slave stalled
        for (int i = 0; i < 3; i++) ga[i] = mk_a(3'd4, 4'd3, 32'h40 * (i + 1), 64'(i + 1));
        out_a_ready = 0;
        in_a_valid = 1; in_a_bits = ga[0];
        #2;
        chk("a_first_ready", in_a_ready, 1);
        chk("a_no_flowthru", out_a_valid, 0);
        cyc();
        in_a_bits = ga[1];
        #2;
        chk("a_second_ready", in_a_ready, 1);
        chk("a_valid_rise", out_a_valid, 1);
        chk("a_head_bits", out_a_bits, ga[0]);
        cyc();
        in_a_bits = ga[2];
        #2;
        chk("a_full_ready", in_a_ready, 0);
        cyc();
        #2;
        chk("a_full_hold_bits", out_a_bits, ga[0]);
        cyc();
        out_a_ready = 1;
        na = 0;
        for (int k = 0; k < 20 && na < 3; k++) begin
            #2;
            fire_in = in_a_valid && in_a_ready;
            if (out_a_valid && out_a_ready) begin
                chk("a_order", out_a_bits, ga[na]);
                na++;
            end
            cyc();
            if (fire_in) in_a_valid = 0;
        end
        chk("a_count", 32'(na), 3);
        out_a_ready = 0;
        cyc();

        // C queue: random handshakes, data must come out 0..9 exactly once
        sent = 0; rcvd = 0;
        for (int k = 0; k < 400 && rcvd < 10; k++) begin
            in_c_valid = (sent < 10) && ($urandom_range(0, 3) != 0);
            in_c_bits = mk_c(3'd4, 4'd3, 64'(sent));
            out_c_ready = ($urandom_range(0, 2) != 0);
            #2;
            if (in_c_valid && in_c_ready) sent++;
            if (out_c_valid && out_c_ready) begin
                chk("c_order", out_c_bits, mk_c(3'd4, 4'd3, 64'(rcvd)));
                rcvd++;
            end
            cyc();
        end
        in_c_valid = 0; out_c_ready = 0;
        chk("c_count", 32'(rcvd), 10);
        #2;
        chk("c_drained", out_c_valid, 0);
        cyc();

        // PutFull size 6 on 64-bit data = 8 beats; quiesce after beat 3
        out_a_ready = 1; nb = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) quiesce_req = 1;
            in_a_valid = 1; in_a_bits = mk_a(3'd0, 4'd6, 32'h1000, 64'h a0 + 64'(i));
            #2;
            chk("burst_accept", in_a_ready, 1);
            if (out_a_valid && out_a_ready) begin
                chk("burst_order", out_a_bits, mk_a(3'd0, 4'd6, 32'h1000, 64'h a0 + 64'(nb)));
                nb++;
            end
            cyc();
        end
        in_a_bits = mk_a(3'd4, 4'd3, 32'h2000, 64'h0);
        #2;
        chk("quiesce_block", in_a_ready, 0);
        chk("idle_busy", idle, 0);
        if (out_a_valid && out_a_ready) begin
            chk("burst_order", out_a_bits, mk_a(3'd0, 4'd6, 32'h1000, 64'h a0 + 64'(nb)));
            nb++;
        end
        cyc();
        in_a_valid = 0;
        got_idle = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (out_a_valid && out_a_ready) begin
                chk("burst_order", out_a_bits, mk_a(3'd0, 4'd6, 32'h1000, 64'h a0 + 64'(nb)));
                nb++;
            end
            if (idle) begin
                got_idle = 1;
                break;
            end
            cyc();
        end
        chk("idle_drained", got_idle, 1);
        chk("burst_count", 32'(nb), 8);
        cyc();
        quiesce_req = 0;
        #2;
        chk("idle_release", idle, 0);
        chk("release_ready", in_a_ready, 1);
        cyc();
        out_a_ready = 0;

        // B and E pass through their queues
        r = rnd128(); bb = r[BW-1:0];
        out_b_valid = 1; out_b_bits = bb;
        in_e_valid = 1; in_e_bits = 2'd3;
        cyc();
        out_b_valid = 0; in_e_valid = 0;
        #2;
        chk("b_valid", in_b_valid, 1);
        chk("b_bits", in_b_bits, bb);
        chk("e_bits", out_e_bits, 2'd3);
        in_b_ready = 1; out_e_ready = 1;
        cyc();
        #2;
        chk("b_drained", in_b_valid, 0);
        chk("e_drained", out_e_valid, 0);
        cyc();
        in_b_ready = 0; out_e_ready = 0;

        // All-wire instance: same-cycle pass, combinational ready, quiesce gate
        r = rnd128();
        z_in_a_bits = {r[AW-1:75], 3'd4, r[70:0]};
        z_in_a_bits[AW-1 -: 3] = 3'd4;
        z_in_a_bits[AW-7 -: 4] = 4'd3;
        z_in_a_valid = 1; z_out_a_ready = 1;
        #2;
        chk("z_a_valid", z_out_a_valid, 1);
        chk("z_a_bits", z_out_a_bits, z_in_a_bits);
        chk("z_a_ready", z_in_a_ready, 1);
        z_in_d_ready = 1;
        #1;
        chk("z_d_ready_hi", z_out_d_ready, 1);
        z_in_d_ready = 0;
        #1;
        chk("z_d_ready_lo", z_out_d_ready, 0);
        cyc();
        z_quiesce = 1;
        #2;
        chk("z_quiesce_valid", z_out_a_valid, 0);
        chk("z_quiesce_ready", z_in_a_ready, 0);
        chk("z_idle", z_idle, 1);
        cyc();
        z_quiesce = 0; z_in_a_valid = 0; z_out_a_ready = 0;

        // Reset with D holding 2 beats and an A burst half-open
        d1 = DW'(rnd128()); d2 = DW'(rnd128()); d3 = DW'(rnd128());
        in_d_ready = 0;
        out_d_valid = 1; out_d_bits = d1;
        in_a_valid = 1; in_a_bits = mk_a(3'd0, 4'd6, 32'h3000, 64'h1);
        cyc();
        out_d_bits = d2;
        in_a_bits = mk_a(3'd0, 4'd6, 32'h3000, 64'h2);
        cyc();
        out_d_valid = 0; in_a_valid = 0;
        #2;
        chk("d_held_valid", in_d_valid, 1);
        chk("d_held_bits", in_d_bits, d1);
        chk("d_full_ready", out_d_ready, 0);
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        #2;
        chk("d_flushed", in_d_valid, 0);
        chk("a_flushed", out_a_valid, 0);
        chk("d_ready_after_rst", out_d_ready, 1);
        quiesce_req = 1;
        #1;
        chk("reset_midburst_idle", idle, 1);
        cyc();
        out_d_valid = 1; out_d_bits = d3;
        cyc();
        out_d_valid = 0; in_d_ready = 1;
        #2;
        chk("d_fresh_valid", in_d_valid, 1);
        chk("d_fresh_bits", in_d_bits, d3);
        cyc();
        #2;
        chk("d_fresh_drained", in_d_valid, 0);
        cyc();
        quiesce_req = 0; in_d_ready = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
